// File: rtl/slant_rd_arbiter.sv
// Two-requester read arbiter for the slant Y/C frame memory: HDMI has priority, Tx gets a guaranteed slot
// after STARVE_MAX lost conflicts when SLANT_ARB_STARVE_GUARD_EN is defined (strict HDMI priority otherwise).
module slant_rd_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 40,
  parameter int STARVE_MAX = 4
) (
  input  logic              Cclk,
  input  logic              rst,
  input  logic              hdmi_req,
  input  logic [ADDR_W-1:0] hdmi_addr,
  output logic              hdmi_gnt,
  output logic              hdmi_rvalid,
  output logic [DATA_W-1:0] hdmi_rdata,
  input  logic              tx_req,
  input  logic [ADDR_W-1:0] tx_addr,
  output logic              tx_gnt,
  output logic              tx_rvalid,
  output logic [DATA_W-1:0] tx_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic conflict;
  logic force_tx;

  assign conflict = hdmi_req & tx_req;

`ifdef SLANT_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign force_tx = (starve_cnt_q == STARVE_LIM);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (tx_gnt || !tx_req)
      starve_cnt_d = 4'd0;
    else if (conflict && hdmi_gnt && (starve_cnt_q != STARVE_LIM))
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge Cclk) begin
    if (rst) starve_cnt_q <= 4'd0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_tx = 1'b0;
`endif

  // Grants are combinational and suppressed while reset is held
  always_comb begin
    hdmi_gnt = ~rst & hdmi_req & ~(tx_req & force_tx);
    tx_gnt   = ~rst & tx_req & (~hdmi_req | force_tx);
  end

  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              own_tx_p1_q, own_tx_p1_d;
  logic              own_vld_p2_q, own_vld_p2_d;
  logic              own_tx_p2_q, own_tx_p2_d;
  logic              hdmi_rvalid_q, hdmi_rvalid_d;
  logic              tx_rvalid_q, tx_rvalid_d;
  logic [DATA_W-1:0] hdmi_rdata_q, hdmi_rdata_d;
  logic [DATA_W-1:0] tx_rdata_q, tx_rdata_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    // p1: issue to memory; mem_en doubles as the stage-1 owner valid
    mem_en_d    = hdmi_gnt | tx_gnt;
    mem_addr_d  = mem_addr_q;
    if (hdmi_gnt)    mem_addr_d = hdmi_addr;
    else if (tx_gnt) mem_addr_d = tx_addr;
    own_tx_p1_d = tx_gnt;
    // p2: memory data is valid during this stage
    own_vld_p2_d = mem_en_q;
    own_tx_p2_d  = own_tx_p1_q;
    // p3: capture into the owner's return register
    hdmi_rvalid_d = own_vld_p2_q & ~own_tx_p2_q;
    tx_rvalid_d   = own_vld_p2_q & own_tx_p2_q;
    hdmi_rdata_d  = hdmi_rvalid_d ? mem_rdata : hdmi_rdata_q;
    tx_rdata_d    = tx_rvalid_d ? mem_rdata : tx_rdata_q;
    conflict_cnt_d = conflict ? sat_inc16(conflict_cnt_q) : conflict_cnt_q;
  end

  always_ff @(posedge Cclk) begin
    if (rst) begin
      mem_en_q       <= 1'b0;
      mem_addr_q     <= '0;
      own_tx_p1_q    <= 1'b0;
      own_vld_p2_q   <= 1'b0;
      own_tx_p2_q    <= 1'b0;
      hdmi_rvalid_q  <= 1'b0;
      tx_rvalid_q    <= 1'b0;
      hdmi_rdata_q   <= '0;
      tx_rdata_q     <= '0;
      conflict_cnt_q <= 16'd0;
    end else begin
      mem_en_q       <= mem_en_d;
      mem_addr_q     <= mem_addr_d;
      own_tx_p1_q    <= own_tx_p1_d;
      own_vld_p2_q   <= own_vld_p2_d;
      own_tx_p2_q    <= own_tx_p2_d;
      hdmi_rvalid_q  <= hdmi_rvalid_d;
      tx_rvalid_q    <= tx_rvalid_d;
      hdmi_rdata_q   <= hdmi_rdata_d;
      tx_rdata_q     <= tx_rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;
  assign hdmi_rvalid  = hdmi_rvalid_q;
  assign tx_rvalid    = tx_rvalid_q;
  assign hdmi_rdata   = hdmi_rdata_q;
  assign tx_rdata     = tx_rdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_slant_rd_arbiter.sv
// Bench for slant_rd_arbiter: transaction-level model (grant rule, return queue keyed by due cycle)
// checked every cycle, plus directed literal expectations for each scenario.
module tb_slant_rd_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 40;
  localparam int STARVE_MAX = 4;
`ifdef SLANT_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              Cclk = 1'b0;
  logic              rst;
  logic              hdmi_req, tx_req;
  logic [ADDR_W-1:0] hdmi_addr, tx_addr;
  logic              hdmi_gnt, tx_gnt, hdmi_rvalid, tx_rvalid, mem_en;
  logic [DATA_W-1:0] hdmi_rdata, tx_rdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       conflict_cnt;

  int n_chk = 0;
  int n_err = 0;

  slant_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .Cclk(Cclk), .rst(rst),
    .hdmi_req(hdmi_req), .hdmi_addr(hdmi_addr), .hdmi_gnt(hdmi_gnt),
    .hdmi_rvalid(hdmi_rvalid), .hdmi_rdata(hdmi_rdata),
    .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt),
    .tx_rvalid(tx_rvalid), .tx_rdata(tx_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 Cclk = ~Cclk;

  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return {a ^ 16'hA5C3, 8'h3C, a};
  endfunction

  // Memory with one cycle of read latency; junk when not enabled
  always @(posedge Cclk) mem_rdata <= mem_en ? mem_f(mem_addr) : 40'hEE_EEEE_EEEE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int              due;
    bit              is_tx;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              q[$];
  bit                live = 1'b0;
  int                cyc_n = 0;
  int                starve_m = 0;
  int                cc_m = 0;
  logic              m_men = 1'b0;
  logic [ADDR_W-1:0] m_maddr = '0;
  logic [DATA_W-1:0] m_hrd = '0, m_trd = '0;

  always @(negedge Cclk) begin : cmp
    logic eh, et, rh, rt, conf, force_tx;
    cyc_n++;
    conf = hdmi_req && tx_req;
    force_tx = GUARD && (starve_m == STARVE_MAX);
    eh = !rst && hdmi_req && !(tx_req && force_tx);
    et = !rst && tx_req && !eh;
    if (live) begin
      rh = 1'b0;
      rt = 1'b0;
      while (q.size() > 0 && q[0].due == cyc_n) begin
        if (q[0].is_tx) begin rt = 1'b1; m_trd = q[0].data; end
        else            begin rh = 1'b1; m_hrd = q[0].data; end
        void'(q.pop_front());
      end
      chk("hdmi_gnt", 64'(hdmi_gnt), 64'(eh));
      chk("tx_gnt", 64'(tx_gnt), 64'(et));
      chk("mem_en", 64'(mem_en), 64'(m_men));
      chk("mem_addr", 64'(mem_addr), 64'(m_maddr));
      chk("hdmi_rvalid", 64'(hdmi_rvalid), 64'(rh));
      chk("tx_rvalid", 64'(tx_rvalid), 64'(rt));
      chk("hdmi_rdata", 64'(hdmi_rdata), 64'(m_hrd));
      chk("tx_rdata", 64'(tx_rdata), 64'(m_trd));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(cc_m));
    end
    if (rst) begin
      live = 1'b1;
      q.delete();
      starve_m = 0;
      cc_m = 0;
      m_men = 1'b0;
      m_maddr = '0;
      m_hrd = '0;
      m_trd = '0;
    end else begin
      if (conf && cc_m < 65535) cc_m++;
      if (et || !tx_req) starve_m = 0;
      else if (conf && eh && starve_m < STARVE_MAX) starve_m++;
      m_men = eh || et;
      if (eh) begin
        m_maddr = hdmi_addr;
        q.push_back('{due: cyc_n + 3, is_tx: 1'b0, data: mem_f(hdmi_addr)});
      end else if (et) begin
        m_maddr = tx_addr;
        q.push_back('{due: cyc_n + 3, is_tx: 1'b1, data: mem_f(tx_addr)});
      end
    end
  end

  task automatic tick();
    @(posedge Cclk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    hdmi_req = 1'b0;
    tx_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int ntx;

  initial begin
    rst = 1'b1;
    hdmi_req = 1'b0;
    tx_req = 1'b0;
    hdmi_addr = '0;
    tx_addr = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Idle
    repeat (20) tick();
    chk("idle_mem_en", 64'(mem_en), 64'd0);
    chk("idle_conflict", 64'(conflict_cnt), 64'd0);
    chk("idle_rvalid", 64'({hdmi_rvalid, tx_rvalid}), 64'd0);

    // Single Tx read
    tx_req = 1'b1;
    tx_addr = 16'h0123;
    #1;
    chk("single_tx_gnt", 64'({hdmi_gnt, tx_gnt}), 64'b01);
    tick();
    tx_req = 1'b0;
    chk("single_mem_en", 64'(mem_en), 64'd1);
    chk("single_mem_addr", 64'(mem_addr), 64'h0123);
    tick();
    chk("single_early_rvalid", 64'(tx_rvalid), 64'd0);
    tick();
    chk("single_tx_rvalid", 64'(tx_rvalid), 64'd1);
    chk("single_tx_rdata", 64'(tx_rdata), 64'hA4E03C0123);
    chk("single_hdmi_rvalid", 64'(hdmi_rvalid), 64'd0);
    tick();
    chk("single_rvalid_pulse", 64'(tx_rvalid), 64'd0);

    // Sustained conflict, addresses changing while held
    do_reset();
    ntx = 0;
    hdmi_req = 1'b1;
    tx_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hdmi_addr = 16'h1000 + 16'(i);
      tx_addr = 16'h2000 + 16'(i);
      #1;
      if (tx_gnt) ntx++;
      tick();
    end
    hdmi_req = 1'b0;
    tx_req = 1'b0;
    chk("conflict_tx_grants", 64'(ntx), GUARD ? 64'd2 : 64'd0);
    chk("conflict_count10", 64'(conflict_cnt), 64'd10);
    repeat (5) tick();

    // Reset with two reads in flight
    hdmi_req = 1'b1;
    hdmi_addr = 16'h0ABC;
    tick();
    hdmi_req = 1'b0;
    tx_req = 1'b1;
    tx_addr = 16'h0DEF;
    tick();
    tx_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'({hdmi_rdata, tx_rdata}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_rvalid", 64'({hdmi_rvalid, tx_rvalid}), 64'd0);
      tick();
    end

    // Saturation of conflict_cnt
    do_reset();
    hdmi_req = 1'b1;
    tx_req = 1'b1;
    hdmi_addr = 16'h4444;
    tx_addr = 16'h5555;
    repeat (65534) tick();
    chk("sat_preload", 64'(conflict_cnt), 64'hFFFE);
    tick();
    chk("sat_reach", 64'(conflict_cnt), 64'hFFFF);
    repeat (2) tick();
    chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
    hdmi_req = 1'b0;
    tx_req = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
